branch_cond_unit: RTL and testbench

//  Consumer end of the ALU flag interface: accepts result/zero/carry/negative/overflow from the compare ALU
//  (slt/sltu/sub) with a valid/ready handshake, registers them, evaluates a branch condition code and

---
 rtl/branch_cond_unit_if.sv | 32 +++
 rtl/branch_cond_unit.sv | 140 ++++++++++++++
 tb/tb_branch_cond_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/branch_cond_unit_if.sv
// Handshake bundle between the compare ALU (producer), branch_cond_unit and fetch (consumer).
interface branch_cond_unit_if #(
   parameter int DW   = 32,
   parameter int OFFW = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   result;
   logic            zero;
   logic            carry;
   logic            negative;
   logic            overflow;
   logic [3:0]      cond;
   logic [DW-1:0]   pc;
   logic [OFFW-1:0] offset;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic            taken;
   logic [DW-1:0]   target;
   logic [3:0]      flags_q;

   modport master (
      output in_valid, result, zero, carry, negative, overflow, cond, pc, offset, flush, out_ready,
      input  in_ready, out_valid, taken, target, flags_q
   );

   modport slave (
      input  in_valid, result, zero, carry, negative, overflow, cond, pc, offset, flush, out_ready,
      output in_ready, out_valid, taken, target, flags_q
   );
endinterface

// File: rtl/branch_cond_unit.sv
// One-entry branch decision stage: registers ALU flags, evaluates cond, emits taken/target redirect.
// Optional BRU_PERF_CNT_EN adds saturating taken/not-taken handshake counters.
//
// state   | meaning
// S_EMPTY | no decision held, out_valid=0
// S_FULL  | decision held on taken/target, out_valid=1
module branch_cond_unit #(
   parameter int DW   = 32,
   parameter int OFFW = 16,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef BRU_PERF_CNT_EN
   output logic [CNTW-1:0]      cnt_taken,
   output logic [CNTW-1:0]      cnt_ntaken,
`endif
   branch_cond_unit_if.slave    bus
);

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   localparam logic [3:0] C_EQ     = 4'd0;
   localparam logic [3:0] C_NE     = 4'd1;
   localparam logic [3:0] C_LT     = 4'd2;
   localparam logic [3:0] C_GE     = 4'd3;
   localparam logic [3:0] C_LTU    = 4'd4;
   localparam logic [3:0] C_GEU    = 4'd5;
   localparam logic [3:0] C_SLT    = 4'd6;
   localparam logic [3:0] C_SLTZ   = 4'd7;
   localparam logic [3:0] C_GTZ    = 4'd8;
   localparam logic [3:0] C_LEZ    = 4'd9;
   localparam logic [3:0] C_ALWAYS = 4'd10;

   state_t          state, state_nxt;
   logic            rdy_q;
   logic            accept;
   logic            out_valid_nxt;
   logic            taken_d;
   logic            lt_signed;
   logic [DW-1:0]   offset_ext;
   logic [DW-1:0]   pc_plus4;
   logic [DW-1:0]   target_d;
   logic            taken_r;
   logic [DW-1:0]   target_r;
   logic [3:0]      flags_r;

   // in_ready held low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   assign bus.in_ready = rdy_q && !bus.flush && ((state == S_EMPTY) || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      out_valid_nxt = 1'b0;
      case (state)
         S_EMPTY: begin
            if (accept) state_nxt = S_FULL;
         end
         S_FULL: begin
            if (bus.flush)          state_nxt = S_EMPTY;
            else if (accept)        state_nxt = S_FULL;
            else if (bus.out_ready) state_nxt = S_EMPTY;
         end
         default: state_nxt = S_EMPTY;
      endcase
      out_valid_nxt = (state_nxt == S_FULL);
   end

   assign bus.out_valid = (state == S_FULL);

   assign lt_signed = bus.negative ^ bus.overflow;

   always_comb begin
      taken_d = 1'b0;
      case (bus.cond)
         C_EQ:     taken_d = bus.zero;
         C_NE:     taken_d = !bus.zero;
         C_LT:     taken_d = lt_signed;
         C_GE:     taken_d = !lt_signed;
         C_LTU:    taken_d = bus.carry;
         C_GEU:    taken_d = !bus.carry;
         C_SLT:    taken_d = bus.result[0];
         C_SLTZ:   taken_d = !bus.result[0];
         C_GTZ:    taken_d = !bus.zero && !lt_signed;
         C_LEZ:    taken_d = bus.zero || lt_signed;
         C_ALWAYS: taken_d = 1'b1;
         default:  taken_d = 1'b0;
      endcase
   end

   // Offset is a signed word count; arithmetic wraps modulo 2^DW.
   assign offset_ext = {{(DW-OFFW){bus.offset[OFFW-1]}}, bus.offset};
   assign pc_plus4   = bus.pc + DW'(4);
   assign target_d   = taken_d ? (pc_plus4 + (offset_ext << 2)) : pc_plus4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_r  <= 1'b0;
         target_r <= '0;
         flags_r  <= '0;
      end else if (accept) begin
         taken_r  <= taken_d;
         target_r <= target_d;
         flags_r  <= {bus.negative, bus.overflow, bus.carry, bus.zero};
      end
   end

   assign bus.taken   = taken_r;
   assign bus.target  = target_r;
   assign bus.flags_q = flags_r;

`ifdef BRU_PERF_CNT_EN
   logic out_hs;
   // A decision killed by flush in the same cycle is not considered delivered.
   assign out_hs = bus.out_valid && bus.out_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_taken  <= '0;
         cnt_ntaken <= '0;
      end else if (out_hs) begin
         if (taken_r && (cnt_taken != {CNTW{1'b1}}))
            cnt_taken <= cnt_taken + CNTW'(1);
         if (!taken_r && (cnt_ntaken != {CNTW{1'b1}}))
            cnt_ntaken <= cnt_ntaken + CNTW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed, table-driven bench for branch_cond_unit plus hand-written stall/flush/reset sequences.
module tb_branch_cond_unit;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   branch_cond_unit_if #(.DW(32), .OFFW(16)) bus ();

`ifdef BRU_PERF_CNT_EN
   logic [15:0] cnt_taken;
   logic [15:0] cnt_ntaken;
`endif

   branch_cond_unit #(.DW(32), .OFFW(16), .CNTW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef BRU_PERF_CNT_EN
      .cnt_taken  (cnt_taken),
      .cnt_ntaken (cnt_ntaken),
`endif
      .bus        (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cond;
      logic        n, v, c, z;
      logic [31:0] result;
      logic [31:0] pc;
      logic [15:0] offset;
      logic        exp_taken;
      logic [31:0] exp_target;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      bus.cond     = t.cond;
      bus.negative = t.n;
      bus.overflow = t.v;
      bus.carry    = t.c;
      bus.zero     = t.z;
      bus.result   = t.result;
      bus.pc       = t.pc;
      bus.offset   = t.offset;
   endtask

   function automatic vec_t mk(input logic [3:0] cond, input logic n, v, c, z,
                               input logic [31:0] result, pc, input logic [15:0] offset,
                               input logic exp_taken, input logic [31:0] exp_target);
      vec_t t;
      t.cond = cond; t.n = n; t.v = v; t.c = c; t.z = z;
      t.result = result; t.pc = pc; t.offset = offset;
      t.exp_taken = exp_taken; t.exp_target = exp_target;
      return t;
   endfunction

   vec_t va, vb, vc;

   initial begin
      n_vec = 0;
      n_err = 0;
      //             cond   n    v    c    z   result  pc            offset    tk   target
      vecs[0]  = mk(4'd0,  0,   0,   0,   1,  32'd0, 32'h00400000, 16'h0003, 1, 32'h00400010);
      vecs[1]  = mk(4'd1,  0,   0,   0,   1,  32'd0, 32'h00001000, 16'h0005, 0, 32'h00001004);
      vecs[2]  = mk(4'd2,  1,   0,   0,   0,  32'd0, 32'h00001000, 16'hFFFE, 1, 32'h00000FFC);
      vecs[3]  = mk(4'd3,  1,   1,   0,   0,  32'd0, 32'h00002000, 16'h0001, 1, 32'h00002008);
      vecs[4]  = mk(4'd4,  0,   0,   0,   0,  32'd0, 32'h00000100, 16'h0007, 0, 32'h00000104);
      vecs[5]  = mk(4'd5,  0,   0,   0,   0,  32'd0, 32'h00000100, 16'h0007, 1, 32'h00000120);
      vecs[6]  = mk(4'd6,  0,   0,   1,   0,  32'd1, 32'h00000200, 16'h0000, 1, 32'h00000204);
      vecs[7]  = mk(4'd7,  0,   0,   1,   0,  32'd1, 32'h00000200, 16'h0004, 0, 32'h00000204);
      vecs[8]  = mk(4'd8,  0,   0,   0,   0,  32'd5, 32'h00000300, 16'h0010, 1, 32'h00000344);
      vecs[9]  = mk(4'd9,  0,   1,   0,   0,  32'd0, 32'h00000300, 16'h0010, 1, 32'h00000344);
      vecs[10] = mk(4'd10, 0,   0,   0,   0,  32'd0, 32'h00000000, 16'hFFFF, 1, 32'h00000000);
      vecs[11] = mk(4'd11, 0,   0,   0,   1,  32'd0, 32'hFFFFFFFC, 16'h0005, 0, 32'h00000000);
      vecs[12] = mk(4'd15, 1,   1,   1,   1,  32'd1, 32'h00000040, 16'h0002, 0, 32'h00000044);
      vecs[13] = mk(4'd8,  0,   0,   0,   1,  32'd0, 32'h00000300, 16'h0010, 0, 32'h00000304);

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      drive(vecs[0]);
      #2;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset taken",     32'(bus.taken),     32'd0);
      chk("reset target",    bus.target,         32'd0);
      chk("reset flags_q",   32'(bus.flags_q),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready after reset", 32'(bus.in_ready), 32'd1);

      // Table: full throughput, one op per cycle with out_ready=1.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("vec%0d taken", i),     32'(bus.taken),     32'(vecs[i].exp_taken));
         chk($sformatf("vec%0d target", i),    bus.target,         vecs[i].exp_target);
         chk($sformatf("vec%0d flags_q", i),   32'(bus.flags_q),
             32'({vecs[i].n, vecs[i].v, vecs[i].c, vecs[i].z}));
      end
      @(posedge clk); #1;
      chk("drain out_valid", 32'(bus.out_valid), 32'd0);

      // Backpressure: A held for 3 cycles while B waits, then B accepted as A drains.
      va = vecs[0];
      vb = vecs[5];
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(va);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      drive(vb);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
         chk($sformatf("stall%0d out_valid", k), 32'(bus.out_valid), 32'd1);
         chk($sformatf("stall%0d target", k), bus.target, va.exp_target);
         chk($sformatf("stall%0d taken", k), 32'(bus.taken), 32'(va.exp_taken));
         @(posedge clk); #1;
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("release in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("B out_valid", 32'(bus.out_valid), 32'd1);
      chk("B target", bus.target, vb.exp_target);
      chk("B flags_q", 32'(bus.flags_q), 32'({vb.n, vb.v, vb.c, vb.z}));

      // Flush while B is held and C is offered: both dropped, flags_q keeps B.
      vc = vecs[12];
      @(negedge clk);
      drive(vc);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.flush     = 1'b1;
      #1;
      chk("flush in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush flags_q", 32'(bus.flags_q), 32'({vb.n, vb.v, vb.c, vb.z}));
      chk("flush target", bus.target, vb.exp_target);
      @(posedge clk); #1;
      chk("post-flush out_valid", 32'(bus.out_valid), 32'd0);

      // Async reset while a decision is stalled.
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(vecs[8]);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", 32'(bus.out_valid), 32'd0);
      chk("async taken",     32'(bus.taken),     32'd0);
      chk("async target",    bus.target,         32'd0);
      chk("async flags_q",   32'(bus.flags_q),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post-reset out_valid", 32'(bus.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
